// File: rtl/zero_countdown_pkg.sv
// ----------------------------------------------------------------------------
// zero_countdown_pkg
// Shared definitions for the zero_countdown block and its testbench:
//   - CNT_W    : counter width (kept at 8 so the zero test maps onto a single
//                equal-zero comparator instance)
//   - state_t  : controller state encoding (IDLE=00, RUN=01, DONE=10)
// ----------------------------------------------------------------------------
package zero_countdown_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : zero_countdown_pkg

// File: rtl/zero_countdown_equal_zero.sv
// ----------------------------------------------------------------------------
// zero_countdown_equal_zero
// Purely combinational equal-to-zero detector.
// Ports:
//   i_a    [WIDTH-1:0]  value under test
//   o_zero              high iff i_a == 0
// ----------------------------------------------------------------------------
module zero_countdown_equal_zero #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  output logic             o_zero
);

  assign o_zero = (i_a == '0);

endmodule : zero_countdown_equal_zero

// File: rtl/zero_countdown.sv
// ----------------------------------------------------------------------------
// zero_countdown
// Loadable down-counter with an IDLE/RUN/DONE controller, optional
// auto-reload and a registered one-cycle terminal-count pulse.
// Per-cycle priority: ABORT > LOAD > ACK > count.
// Ports:
//   i_clk           rising-edge clock
//   i_rst_n         asynchronous active-low reset
//   i_load          start/restart; i_d becomes count and reload value
//   i_d   [WIDTH]   load value
//   i_en            count enable (low stalls the count in RUN)
//   i_auto          auto-reload, sampled at each terminal count
//   i_abort         cancel current operation (back to IDLE, Q = 0)
//   i_ack           acknowledges DONE
//   o_q   [WIDTH]   current count (registered)
//   o_zero          high iff o_q == 0 (combinational)
//   o_busy          high iff state == RUN
//   o_done          high iff state == DONE
//   o_tc            registered one-cycle terminal-count pulse
// ----------------------------------------------------------------------------
module zero_countdown
  import zero_countdown_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  input  logic             i_auto,
  input  logic             i_abort,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_q,
  output logic             o_zero,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_tc
);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_tc_nxt;

  // All state in one clocked process; reset acts immediately, so a reset
  // mid-count clears Q and TC without waiting for an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;

    if (i_abort) begin
      // Reload register intentionally kept.
      w_state_nxt = ST_IDLE;
      w_q_nxt     = '0;
    end else if (i_load) begin
      if (i_d != '0) begin
        // Restart discards any in-progress count without a TC.
        w_state_nxt  = ST_RUN;
        w_q_nxt      = i_d;
        w_reload_nxt = i_d;
      end else begin
        // Loading zero is an immediate terminal count.
        w_state_nxt = ST_DONE;
        w_q_nxt     = '0;
        w_tc_nxt    = 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (i_en) begin
            // RUN is only entered with a non-zero count, so Q == 1 is the
            // last step and the decrement below can never wrap.
            if (r_q == WIDTH'(1)) begin
              w_tc_nxt = 1'b1;
              if (i_auto) begin
                w_q_nxt = r_reload;
              end else begin
                w_q_nxt     = '0;
                w_state_nxt = ST_DONE;
              end
            end else begin
              w_q_nxt = r_q - WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          if (i_ack) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          // IDLE: count held, EN and ACK ignored.
        end
      endcase
    end
  end

  zero_countdown_equal_zero #(
    .WIDTH (WIDTH)
  ) u_equal_zero (
    .i_a    (r_q),
    .o_zero (o_zero)
  );

  assign o_q    = r_q;
  assign o_tc   = r_tc;
  assign o_busy = (r_state == ST_RUN);
  assign o_done = (r_state == ST_DONE);

endmodule : zero_countdown
